// File: rtl/tdc_readout_arbiter.sv
// Round-robin readout scheduler for NCH TDC hit FIFOs; emits {channel, word} on a valid/ready stream.
// Optional feature: define TDC_ARB_CHMASK_EN to add the chan_mask input (per-channel read enable mask).
module tdc_readout_arbiter #(
  parameter int NCH    = 4,
  parameter int CHW    = 2,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                SYSCLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      fifo_avail,
  input  logic [NCH*DW-1:0]   fifo_dout,
  output logic [NCH-1:0]      fifo_rd,
  output logic [CHW+DW-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef TDC_ARB_CHMASK_EN
  input  logic [NCH-1:0]      chan_mask,
`endif
  output logic                busy,
  output logic [15:0]         word_count
);

  if (CHW != $clog2(NCH)) begin : g_chw_check
    $error("tdc_readout_arbiter: CHW must equal clog2(NCH)");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_check
    $error("tdc_readout_arbiter: RD_LAT must be 1..3");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t           state, state_next;
  logic [CHW-1:0]   grant, last_grant, next_grant;
  logic [1:0]       lat_cnt;
  logic [NCH-1:0]   eligible;
  logic             any_eligible;
  logic             capture, accept;
  logic [DW-1:0]    dout_ch [NCH];

`ifdef TDC_ARB_CHMASK_EN
  assign eligible = fifo_avail & chan_mask;
`else
  assign eligible = fifo_avail;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      dout_ch[i] = fifo_dout[i*DW +: DW];
    end
  end

  // Search downward so the nearest successor of last_grant is the one that sticks.
  always_comb begin
    any_eligible = 1'b0;
    next_grant   = last_grant;
    for (int k = NCH; k >= 1; k--) begin
      if (eligible[CHW'((int'(last_grant) + k) % NCH)]) begin
        any_eligible = 1'b1;
        next_grant   = CHW'((int'(last_grant) + k) % NCH);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    fifo_rd    = '0;
    out_valid  = 1'b0;
    busy       = (state != S_IDLE);
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_eligible) state_next = S_READ;
      end
      S_READ: begin
        fifo_rd[grant] = 1'b1;
        state_next     = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == 2'(RD_LAT - 1)) begin
          capture    = 1'b1;
          state_next = S_PRESENT;
        end
      end
      S_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          accept     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so a
  // word in flight is dropped the moment RESET rises.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= CHW'(NCH - 1);
      lat_cnt    <= '0;
      out_data   <= '0;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && any_eligible) grant <= next_grant;
      if (state == S_READ) lat_cnt <= '0;
      else if (state == S_WAIT) lat_cnt <= lat_cnt + 2'd1;
      if (capture) out_data <= {grant, dout_ch[grant]};
      if (accept) begin
        word_count <= word_count + 16'd1;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Scoreboard bench for tdc_readout_arbiter: a FIFO model feeds the DUT, expected reads/words are queued.
// Define TDC_ARB_CHMASK_EN to also run the channel-mask scenario.
module tb_tdc_readout_arbiter;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic [3:0]  fifo_avail;
  logic [31:0] fifo_dout;
  logic [3:0]  fifo_rd;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] word_count;
`ifdef TDC_ARB_CHMASK_EN
  logic [3:0]  chan_mask;
`endif

  tdc_readout_arbiter #(.NCH(4), .CHW(2), .DW(8), .RD_LAT(1)) dut (
    .SYSCLK     (SYSCLK),
    .RESET      (RESET),
    .fifo_avail (fifo_avail),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef TDC_ARB_CHMASK_EN
    .chan_mask  (chan_mask),
`endif
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: word for channel i is base[i] + number of reads so far, valid one cycle after rd.
  logic [7:0] base [4];
  int         rd_cnt [4];
  always @(posedge SYSCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (fifo_rd[i]) begin
        fifo_dout[i*8 +: 8] <= base[i] + 8'(rd_cnt[i]);
        rd_cnt[i]           <= rd_cnt[i] + 1;
      end
    end
  end

  // Scoreboard
  int          exp_rd_q [$];
  logic [9:0]  exp_out_q [$];
  int          exp_cnt [4];
  logic [15:0] exp_wc = '0;

  task automatic expect_word(input int ch);
    exp_rd_q.push_back(ch);
    exp_out_q.push_back({2'(ch), base[ch] + 8'(exp_cnt[ch])});
    exp_cnt[ch]++;
  endtask

  initial begin
    forever begin
      @(negedge SYSCLK);
      #1;
      if (!RESET) begin
        if (fifo_rd != 4'b0000) begin
          if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(fifo_rd), 32'd0);
          else check("rd_grant", 32'(fifo_rd), 32'd1 << exp_rd_q.pop_front());
        end
        if (out_valid && out_ready) begin
          check("wc_at_handshake", 32'(word_count), 32'(exp_wc));
          if (exp_out_q.size() == 0) check("out_unexpected", 32'(out_valid), 32'd0);
          else check("out_data", 32'(out_data), 32'(exp_out_q.pop_front()));
          exp_wc++;
        end
      end
    end
  end

  task automatic wait_rd_drain(input string tag);
    int n = 0;
    while (exp_rd_q.size() != 0 && n < 200) begin
      @(negedge SYSCLK);
      n++;
    end
    check(tag, 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic wait_out_drain(input string tag);
    int n = 0;
    while (exp_out_q.size() != 0 && n < 200) begin
      @(negedge SYSCLK);
      n++;
    end
    check(tag, 32'(exp_out_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge SYSCLK);
      n++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge SYSCLK);
    RESET      = 1'b1;
    fifo_avail = 4'b0000;
    #1;
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(negedge SYSCLK);
    RESET = 1'b0;
    exp_rd_q.delete();
    exp_out_q.delete();
    exp_wc = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET      = 1'b1;
    fifo_avail = 4'b0000;
    out_ready  = 1'b1;
`ifdef TDC_ARB_CHMASK_EN
    chan_mask  = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) base[i] = 8'h10 + 8'(i * 32);

    // 1: single word on ch0, exact latency
    do_reset();
    base[0] = 8'h5A - 8'(exp_cnt[0]);
    expect_word(0);
    fifo_avail = 4'b0001;
    @(negedge SYSCLK);
    check("t1_rd_pulse", 32'(fifo_rd), 32'h1);
    check("t1_busy", 32'(busy), 32'd1);
    fifo_avail = 4'b0000;
    @(negedge SYSCLK);
    check("t1_rd_single", 32'(fifo_rd), 32'd0);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    @(negedge SYSCLK);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h05A);
    @(negedge SYSCLK);
    check("t1_wc", 32'(word_count), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: all channels available, round-robin order 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < 8; i++) expect_word(i % 4);
    fifo_avail = 4'b1111;
    wait_rd_drain("t2_rd_drain");
    fifo_avail = 4'b0000;
    wait_out_drain("t2_out_drain");
    check("t2_wc", 32'(word_count), 32'd8);

    // 3: back-pressure while presenting ch2 word 0xC3
    out_ready = 1'b0;
    base[2] = 8'hC3 - 8'(exp_cnt[2]);
    expect_word(2);
    fifo_avail = 4'b0100;
    wait_rd_drain("t3_rd_drain");
    fifo_avail = 4'b1111;
    wait_valid("t3_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge SYSCLK);
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_data", 32'(out_data), 32'h2C3);
      check("t3_hold_no_rd", 32'(fifo_rd), 32'd0);
    end
    expect_word(3);
    out_ready = 1'b1;
    wait_rd_drain("t3_next_rd");
    fifo_avail = 4'b0000;
    wait_out_drain("t3_out_drain");
    check("t3_wc", 32'(word_count), 32'd10);

    // 4: reset during WAIT with ch2 granted
    do_reset();
    expect_word(2);
    fifo_avail = 4'b0100;
    @(negedge SYSCLK);
    fifo_avail = 4'b0000;
    @(negedge SYSCLK);
    check("t4_in_wait", 32'(busy), 32'd1);
    RESET = 1'b1;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_rd", 32'(fifo_rd), 32'd0);
    check("t4_rst_data", 32'(out_data), 32'd0);
    check("t4_rst_wc", 32'(word_count), 32'd0);
    @(negedge SYSCLK);
    RESET = 1'b0;
    exp_out_q.delete();
    exp_wc = '0;
    check("t4_no_valid", 32'(out_valid), 32'd0);
    expect_word(0);
    fifo_avail = 4'b1111;
    wait_rd_drain("t4_rd_drain");
    fifo_avail = 4'b0000;
    wait_out_drain("t4_out_drain");
    check("t4_wc", 32'(word_count), 32'd1);

`ifdef TDC_ARB_CHMASK_EN
    // 5: mask leaves only ch1 and ch3 eligible
    do_reset();
    chan_mask = 4'b1010;
    for (int i = 0; i < 4; i++) expect_word((i % 2 == 0) ? 1 : 3);
    fifo_avail = 4'b1111;
    wait_rd_drain("t5_rd_drain");
    fifo_avail = 4'b0000;
    wait_out_drain("t5_out_drain");
    check("t5_wc", 32'(word_count), 32'd4);
    chan_mask = 4'b1111;
`endif

    // 6: word_count wraps 0xFFFF -> 0
    @(negedge SYSCLK);
    force dut.word_count = 16'hFFFF;
    #1;
    release dut.word_count;
    exp_wc = 16'hFFFF;
    #1;
    check("t6_preload", 32'(word_count), 32'hFFFF);
    expect_word(1);
    fifo_avail = 4'b0010;
    wait_rd_drain("t6_rd_drain");
    fifo_avail = 4'b0000;
    wait_out_drain("t6_out_drain");
    check("t6_wrap", 32'(word_count), 32'd0);

    repeat (3) @(negedge SYSCLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
